// File: rtl/bus_source_arbiter_if.sv
// Source-to-bus handshake bundle: the arbiter drives through the master modport and the
// source/destination side through the slave modport.
interface bus_source_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 24,
  parameter int SEL_WIDTH  = 5,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_SRC-1:0]            src_req;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic                          bus_ready;
  logic [DATA_WIDTH-1:0]         BusMuxOut;
  logic                          bus_valid;
  logic [SEL_WIDTH-1:0]          sel_code;
  logic                          conflict;
  logic                          timeout;
  logic [CNT_WIDTH-1:0]          conflict_count;

  modport master (
    input  src_req, src_data, bus_ready,
    output BusMuxOut, bus_valid, sel_code, conflict, timeout, conflict_count
  );

  modport slave (
    output src_req, src_data, bus_ready,
    input  BusMuxOut, bus_valid, sel_code, conflict, timeout, conflict_count
  );
endinterface

// File: rtl/bus_source_arbiter.sv
// Fixed-priority bus source arbiter: lowest requesting index is registered onto BusMuxOut (1-cycle latency).
// The word is held until bus_ready; requests are ignored while stalled and the word is dropped after TIMEOUT stalls.
module bus_source_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 24,
  parameter int SEL_WIDTH  = 5,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  bus_source_arbiter_if.master  io
);

  localparam int                    HOLD_WIDTH = $clog2(TIMEOUT);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST  = HOLD_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [HOLD_WIDTH-1:0]   hold, hold_nxt;
  logic [DATA_WIDTH-1:0]   word_q, word_nxt;
  logic [SEL_WIDTH-1:0]    sel_q, sel_nxt;
  logic                    conflict_q, conflict_nxt;
  logic                    timeout_q, timeout_nxt;
  logic [CNT_WIDTH-1:0]    count_q, count_nxt;

  logic [SEL_WIDTH-1:0]    win_idx;
  logic [DATA_WIDTH-1:0]   win_word;
  logic                    any_req;
  logic                    multi_req;
  logic                    capture;

  // Descending scan so the lowest set index is the last one written and wins.
  always_comb begin
    win_idx  = '0;
    win_word = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (io.src_req[i]) begin
        win_idx  = SEL_WIDTH'(i);
        win_word = io.src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign any_req   = |io.src_req;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_req = |(io.src_req & (io.src_req - NUM_SRC'(1)));

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold;
    word_nxt     = word_q;
    sel_nxt      = sel_q;
    conflict_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    count_nxt    = count_q;
    capture      = 1'b0;

    case (state)
      IDLE: begin
        capture = any_req;
      end
      DRIVE: begin
        if (io.bus_ready) begin
          capture = any_req;
          if (!any_req) begin
            state_nxt = IDLE;
          end
        end else if (hold == HOLD_LAST) begin
          state_nxt   = IDLE;
          hold_nxt    = '0;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold + HOLD_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (capture) begin
      state_nxt = DRIVE;
      hold_nxt  = '0;
      word_nxt  = win_word;
      sel_nxt   = win_idx;
      if (multi_req) begin
        conflict_nxt = 1'b1;
        if (count_q != CNT_MAX) begin
          count_nxt = count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state      <= IDLE;
      hold       <= '0;
      word_q     <= '0;
      sel_q      <= '0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      word_q     <= word_nxt;
      sel_q      <= sel_nxt;
      conflict_q <= conflict_nxt;
      timeout_q  <= timeout_nxt;
      count_q    <= count_nxt;
    end
  end

  assign io.BusMuxOut      = word_q;
  assign io.bus_valid      = (state == DRIVE);
  assign io.sel_code       = sel_q;
  assign io.conflict       = conflict_q;
  assign io.timeout        = timeout_q;
  assign io.conflict_count = count_q;

endmodule
